unidad_busqueda: RTL

//  Instruction-fetch stage of the RV64 pipeline: owns the PC, issues in-order reads to

---
 rtl/unidad_busqueda.sv | 127 ++++++++++++
 1 files changed

// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads, buffers returned words
// in a small FIFO and presents {instr, pc} to decode; redirects flush and drain stale responses.
`timescale 1ns/1ps
module unidad_busqueda #(
    parameter int                     PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
    parameter int                     FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req_valid,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc,
    input  logic                id_ready,
    output logic [1:0]          estado_dbg
);
    // Handshakes: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
    // a decode transfer happens where id_valid && id_ready; imem_resp_valid is a pulse with no ready.

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ARRANQUE = 2'd0,
        BUSQUEDA = 2'd1,
        DESCARTE = 2'd2
    } estado_t;

    estado_t             estado, estado_sig;
    logic [PC_WIDTH-1:0] pc, resp_pc;
    logic [CW-1:0]       pend, discard, discard_sig, count;
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [31:0]         buf_instr [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] buf_pc    [FIFO_DEPTH];

    logic                redir, fire, acepta, pop;
    logic [CW:0]         ocupado, drenar;
    logic [PC_WIDTH-1:0] destino;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign destino = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign redir   = redirect_valid && (estado != ARRANQUE);
    assign ocupado = {1'b0, pend} + {1'b0, count};

    assign imem_req_valid = (estado == BUSQUEDA) && !redirect_valid &&
                            (ocupado < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are leftovers from before a reset.
    assign acepta         = (estado == BUSQUEDA) && imem_resp_valid && (pend != '0) && !redir;
    assign pop            = (count != '0) && id_ready && !redir;

    assign id_valid   = (count != '0);
    assign id_instr   = id_valid ? buf_instr[rd_ptr] : NOP;
    assign id_pc      = id_valid ? buf_pc[rd_ptr] : '0;
    assign estado_dbg = estado;

    // Words still owed by memory at a redirect, minus one arriving in the same cycle.
    assign drenar = {1'b0, discard} + {1'b0, pend};

    always_comb begin
        discard_sig = discard;
        estado_sig  = estado;
        if (redir) begin
            discard_sig = CW'(drenar - (CW+1)'(imem_resp_valid && (drenar != '0)));
        end else if ((estado == DESCARTE) && imem_resp_valid && (discard != '0)) begin
            discard_sig = discard - CW'(1);
        end
        case (estado)
            ARRANQUE: estado_sig = BUSQUEDA;
            BUSQUEDA: if (redir && (discard_sig != '0)) estado_sig = DESCARTE;
            DESCARTE: if (discard_sig == '0) estado_sig = BUSQUEDA;
            default:  estado_sig = ARRANQUE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado  <= ARRANQUE;
            pc      <= RESET_PC;
            resp_pc <= RESET_PC;
            pend    <= '0;
            discard <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            estado  <= estado_sig;
            discard <= discard_sig;
            if (redir) begin
                pc      <= destino;
                resp_pc <= destino;
                pend    <= '0;
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (fire)   pc      <= pc + PC_WIDTH'(4);
                if (acepta) resp_pc <= resp_pc + PC_WIDTH'(4);
                pend  <= pend + CW'(fire) - CW'(acepta);
                count <= count + CW'(acepta) - CW'(pop);
                if (acepta) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Storage needs no reset: it is only visible through id_valid.
    always_ff @(posedge clk) begin
        if (acepta) begin
            buf_instr[wr_ptr] <= imem_resp_data;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule
